// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
//   Iterative 32x32 multiply (and, optionally, divide) sequencer that borrows
//   a shared combinational ALU one step per cycle and owns the HI/LO registers.
//   Sequence: IDLE -> PREP (1) -> ITER (32) -> FIX (1) -> IDLE, with done
//   pulsing on the cycle after FIX, i.e. the 35th cycle after the start edge.
//
//   Optional feature: define MULT_DIV_SEQ_DIV_EN to build DIV/DIVU support.
//   Without it, a start with op[1]=1 is ignored.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start, op             launch request (IDLE only); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   rs_val, rt_val        multiplicand/dividend, multiplier/divisor
//   mthi_we, mtlo_we      direct HI/LO writes (IDLE only), data on mt_data
//   busy, done            busy in PREP/ITER/FIX; one-cycle completion pulse
//   hi, lo                architectural HI/LO
//   alu_control, alu_src_a, alu_src_b, alu_result   shared ALU request/response
//   state_dbg             current FSM state (0 IDLE, 1 PREP, 2 ITER, 3 FIX)
//
// Handshake: start is a level sampled only on a rising edge while busy=0;
// the operation is accepted on that edge and no further request is taken
// until busy falls. done is high for exactly one cycle per accepted operation.
module mult_div_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00010,
  parameter logic [4:0] ALU_SUB = 5'b00110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [4:0]  alu_control,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  input  logic [31:0] alu_result,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PREP = 2'd1, S_ITER = 2'd2, S_FIX = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        signed_q, signed_d;
  logic        neg_res_q, neg_res_d;
  logic [31:0] a_q, a_d;          // raw rs_val
  logic [31:0] b_q, b_d;          // raw rt_val
  logic [31:0] m_q, m_d;          // multiplicand or divisor magnitude
  logic [31:0] acc_hi_q, acc_hi_d; // product high / remainder
  logic [31:0] acc_lo_q, acc_lo_d; // multiplier->product low / quotient
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        accept;
  logic [31:0] mag_a, mag_b;
  logic        carry;
  logic [63:0] prod;

`ifdef MULT_DIV_SEQ_DIV_EN
  logic        div_q, div_d;
  logic        neg_rem_q, neg_rem_d;
  logic [32:0] r_wide;
  assign accept = start;
`else
  // Divide requests are dropped entirely when division is not built.
  assign accept = start && !op[1];
`endif

  // State register and all datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      neg_res_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULT_DIV_SEQ_DIV_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      neg_res_q <= neg_res_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MULT_DIV_SEQ_DIV_EN
      div_q     <= div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_PREP;
      S_PREP: state_d = S_ITER;
      S_ITER: if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    neg_res_d   = neg_res_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    alu_control = ALU_ADD;
    alu_src_a   = '0;
    alu_src_b   = '0;
    mag_a       = '0;
    mag_b       = '0;
    carry       = 1'b0;
    prod        = '0;
`ifdef MULT_DIV_SEQ_DIV_EN
    div_d       = div_q;
    neg_rem_d   = neg_rem_q;
    r_wide      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d      = rs_val;
          b_d      = rt_val;
          signed_d = ~op[0];
`ifdef MULT_DIV_SEQ_DIV_EN
          div_d    = op[1];
`endif
        end
        if (mthi_we) hi_d = mt_data;
        if (mtlo_we) lo_d = mt_data;
      end
      S_PREP: begin
        mag_a     = (signed_q && a_q[31]) ? -a_q : a_q;
        mag_b     = (signed_q && b_q[31]) ? -b_q : b_q;
        neg_res_d = signed_q & (a_q[31] ^ b_q[31]);
        cnt_d     = '0;
        acc_hi_d  = '0;
        m_d       = mag_a;
        acc_lo_d  = mag_b;
`ifdef MULT_DIV_SEQ_DIV_EN
        neg_rem_d = signed_q & a_q[31];
        if (div_q) begin
          m_d      = mag_b;
          acc_lo_d = mag_a;
        end
`endif
      end
      S_ITER: begin
        cnt_d = cnt_q + 5'd1;
        // Shift-add multiply: the carry out of the 32-bit add is recovered
        // from the ALU result wrapping below its first operand.
        alu_src_a = acc_hi_q;
        alu_src_b = acc_lo_q[0] ? m_q : 32'd0;
        carry     = (alu_result < acc_hi_q);
        acc_hi_d  = {carry, alu_result[31:1]};
        acc_lo_d  = {alu_result[0], acc_lo_q[31:1]};
`ifdef MULT_DIV_SEQ_DIV_EN
        if (div_q) begin
          // Restoring divide; R[32] set means R already exceeds any divisor.
          r_wide      = {acc_hi_q, acc_lo_q[31]};
          alu_control = ALU_SUB;
          alu_src_a   = r_wide[31:0];
          alu_src_b   = m_q;
          if (r_wide[32] || (r_wide[31:0] >= m_q)) begin
            acc_hi_d = alu_result;
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = r_wide[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end
`endif
      end
      S_FIX: begin
        done_d = 1'b1;
        prod   = {acc_hi_q, acc_lo_q};
        if (neg_res_q) prod = -prod;
        hi_d = prod[63:32];
        lo_d = prod[31:0];
`ifdef MULT_DIV_SEQ_DIV_EN
        if (div_q) begin
          if (b_q == 32'd0) begin
            // Zero divisor: all-ones quotient, dividend returned untouched.
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
          end
        end
`endif
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, mt_data, alu_result;
  logic        mthi_we, mtlo_we;
  logic        busy, done;
  logic [31:0] hi, lo, alu_src_a, alu_src_b;
  logic [4:0]  alu_control;
  logic [1:0]  state_dbg;

  int          n_checks;
  int          n_fail;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t mul_vecs[8];
`ifdef MULT_DIV_SEQ_DIV_EN
  vec_t div_vecs[6];
`endif

  mult_div_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .state_dbg(state_dbg)
  );

  // Shared ALU stand-in: subtract on the SUB code, add otherwise.
  assign alu_result = (alu_control == 5'b00110) ? (alu_src_a - alu_src_b)
                                                 : (alu_src_a + alu_src_b);

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one start and count negedges until done (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    lat    = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 60);
  endtask

  task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] d);
    @(negedge clk);
    mthi_we = whi;
    mtlo_we = wlo;
    mt_data = d;
    @(negedge clk);
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          lat;
    logic [63:0] e;
    exp_q.push_back({v.exp_hi, v.exp_lo});
    run_op(v.op, v.rs, v.rt, lat);
    e = exp_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'd35);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int   lat;
    logic saw_busy, saw_done;

    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    op       = 2'b00;
    rs_val   = '0;
    rt_val   = '0;
    mthi_we  = 1'b0;
    mtlo_we  = 1'b0;
    mt_data  = '0;

    mul_vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    mul_vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    mul_vecs[2] = '{OP_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
    mul_vecs[3] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    mul_vecs[4] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    mul_vecs[5] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    mul_vecs[6] = '{OP_MULT,  32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A988};
    mul_vecs[7] = '{OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
`ifdef MULT_DIV_SEQ_DIV_EN
    div_vecs[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    div_vecs[1] = '{OP_DIVU, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    div_vecs[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    div_vecs[3] = '{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    div_vecs[4] = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    div_vecs[5] = '{OP_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
`endif

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_alu_ctl", {59'd0, alu_control}, 64'd2);
    check("rst_alu_a", {32'd0, alu_src_a}, 64'd0);
    check("rst_alu_b", {32'd0, alu_src_b}, 64'd0);
    reset = 1'b0;

    // Table-driven multiply vectors
    for (int i = 0; i < 8; i++) run_vec(mul_vecs[i], $sformatf("mul%0d", i));

`ifdef MULT_DIV_SEQ_DIV_EN
    for (int i = 0; i < 6; i++) run_vec(div_vecs[i], $sformatf("div%0d", i));
`endif

    // Reset in ITER cycle 10 with non-zero HI/LO preloaded
    mt_write(1'b1, 1'b1, 32'hA5A5_A5A5);
    check("preload_hi", {32'd0, hi}, 64'h0000_0000_A5A5_A5A5);
    @(negedge clk);
    start  = 1'b1;
    op     = OP_MULTU;
    rs_val = 32'hFFFF_FFFF;
    rt_val = 32'hFFFF_FFFF;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("iter10_busy", {63'd0, busy}, 64'd1);
    check("iter10_state", {62'd0, state_dbg}, 64'd2);
    reset = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    check("midrst_alu_b", {32'd0, alu_src_b}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_MULTU, 32'd3, 32'd5, lat);
    check("post_rst_latency", 64'(lat), 64'd35);
    check("post_rst_lo", {32'd0, lo}, 64'd15);
    check("post_rst_hi", {32'd0, hi}, 64'd0);

    // start / mthi_we / mtlo_we pulsed mid-ITER must be ignored
    @(negedge clk);
    start  = 1'b1;
    op     = OP_MULTU;
    rs_val = 32'd6;
    rt_val = 32'd7;
    lat    = 0;
    do begin
      @(negedge clk);
      lat++;
      start   = (lat == 15);
      mthi_we = (lat == 15);
      mtlo_we = (lat == 15);
      mt_data = 32'h1234_5678;
      if (lat == 15) rs_val = 32'd9;
    end while (!done && lat < 60);
    check("ignore_latency", 64'(lat), 64'd35);
    check("ignore_hi", {32'd0, hi}, 64'd0);
    check("ignore_lo", {32'd0, lo}, 64'd42);
    saw_busy = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_busy |= busy;
      saw_done |= done;
    end
    check("ignore_no_relaunch_busy", {63'd0, saw_busy}, 64'd0);
    check("ignore_no_relaunch_done", {63'd0, saw_done}, 64'd0);

    // Direct writes in IDLE
    mt_write(1'b1, 1'b0, 32'h1234_5678);
    check("mthi_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    check("mthi_lo_kept", {32'd0, lo}, 64'd42);
    check("mthi_no_done", {63'd0, done}, 64'd0);
    check("mthi_no_busy", {63'd0, busy}, 64'd0);
    mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
    check("mt_both_hi", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);
    check("mt_both_lo", {32'd0, lo}, 64'h0000_0000_CAFE_F00D);

`ifndef MULT_DIV_SEQ_DIV_EN
    // Divide request with division not built: nothing happens
    @(negedge clk);
    start  = 1'b1;
    op     = OP_DIVU;
    rs_val = 32'd100;
    rt_val = 32'd7;
    saw_busy = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      start = 1'b0;
      saw_busy |= busy;
      saw_done |= done;
    end
    check("nodiv_busy", {63'd0, saw_busy}, 64'd0);
    check("nodiv_done", {63'd0, saw_done}, 64'd0);
    check("nodiv_hi", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);
    check("nodiv_lo", {32'd0, lo}, 64'h0000_0000_CAFE_F00D);
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat);
    check("nodiv_mult_latency", 64'(lat), 64'd35);
    check("nodiv_mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
    check("nodiv_mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
